// File: rtl/restore_above_msb.sv
// Undoes invert-above-MSB: the captured word is ANDed with a mask of ones from the MSB index down to bit 0.
// The mask is built by a log-step spread over STAGES cycles, and the result is checked against the index/zero flag.
module restore_above_msb #(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          in_data,
   input  logic [$clog2(N)-1:0]  in_msb,
   input  logic                  in_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          out_data,
   output logic                  out_err
);

   localparam int STAGES = $clog2(N);
   localparam int LAST_I = STAGES - 1;
   localparam logic [STAGES-1:0] LAST_STAGE = LAST_I[STAGES-1:0];

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SPREAD = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              r_state;
   logic [N-1:0]        r_word;
   logic [N-1:0]        r_mask;
   logic [STAGES-1:0]   r_msb;
   logic [STAGES-1:0]   r_stage;
   logic                r_zero;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [N-1:0]        r_out_data;
   logic                r_out_err;

   logic                w_msb_oob;
   logic [N-1:0]        w_onehot;
   logic [N-1:0]        w_mask_load;
   logic [N-1:0]        w_mask_next;
   logic                w_err;

   // One spread step: every set bit also sets the bit 2^stage positions below it.
   function automatic logic [N-1:0] f_spread(input logic [N-1:0] mask, input logic [STAGES-1:0] stage);
      return mask | (mask >> (32'd1 << stage));
   endfunction

   // Consistency of the captured word with its MSB index / zero flag.
   function automatic logic f_err(input logic [N-1:0] word, input logic [STAGES-1:0] msb, input logic zero);
      logic [31:0] idx;
      logic        err;
      idx = 32'(msb);
      err = 1'b0;
      if (zero) begin
         err = (word != {N{1'b1}});
      end else if (idx >= 32'(N)) begin
         err = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) begin
            if ((32'(i) >= idx) && !word[i]) begin
               err = 1'b1;
            end
         end
      end
      return err;
   endfunction

   // Mask seed for a newly accepted word; an out-of-range index seeds nothing.
   always_comb begin
      w_msb_oob   = (32'(in_msb) >= 32'(N));
      w_onehot    = {{(N-1){1'b0}}, 1'b1} << in_msb;
      w_mask_load = (in_zero || w_msb_oob) ? {N{1'b0}} : w_onehot;
   end

   // Next spread step and error flag, derived only from registered state.
   always_comb begin
      w_mask_next = f_spread(r_mask, r_stage);
      w_err       = f_err(r_word, r_msb, r_zero);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_word      <= {N{1'b0}};
         r_mask      <= {N{1'b0}};
         r_msb       <= {STAGES{1'b0}};
         r_stage     <= {STAGES{1'b0}};
         r_zero      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= {N{1'b0}};
         r_out_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_word     <= in_data;
                  r_msb      <= in_msb;
                  r_zero     <= in_zero;
                  r_mask     <= w_mask_load;
                  r_stage    <= {STAGES{1'b0}};
                  r_in_ready <= 1'b0;
                  r_state    <= S_SPREAD;
               end
            end
            S_SPREAD: begin
               r_mask  <= w_mask_next;
               r_stage <= r_stage + STAGES'(1);
               // The final step's mask feeds the output directly so the result appears with out_valid.
               if (r_stage == LAST_STAGE) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_word & w_mask_next;
                  r_out_err   <= w_err;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_out_data  <= {N{1'b0}};
                  r_out_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_data  <= {N{1'b0}};
               r_out_err   <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_restore_above_msb.sv
// Randomized and directed bench for restore_above_msb (N=32) against an arithmetic reference model.
module tb_restore_above_msb;

   localparam int N  = 32;
   localparam int ST = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic [ST-1:0] in_msb;
   logic          in_zero;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
   logic          out_err;

   int n_tests = 0;
   int n_fail  = 0;

   restore_above_msb #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_msb(in_msb), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: keep bits msb..0; the word must be all ones from msb upward.
   function automatic logic [31:0] model_data(input logic [31:0] d, input int msb, input logic z);
      logic [63:0] keep;
      if (z || msb >= N) return 32'd0;
      keep = (64'd1 << (msb + 1)) - 64'd1;
      return d & keep[31:0];
   endfunction

   function automatic logic model_err(input logic [31:0] d, input int msb, input logic z);
      logic [63:0] below;
      if (z) return d != 32'hFFFF_FFFF;
      if (msb >= N) return 1'b1;
      below = (64'd1 << msb) - 64'd1;
      return (d | below[31:0]) != 32'hFFFF_FFFF;
   endfunction

   task automatic junk_inputs();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_msb    = 5'($urandom);
      in_zero   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] d, input int msb, input logic z, input int hold);
      int          w;
      int          lat;
      logic [31:0] ed;
      logic        ee;
      ed = model_data(d, msb, z);
      ee = model_err(d, msb, z);
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("idle_ready", {63'd0, in_ready}, 64'd1);
      in_valid  = 1'b1;
      in_data   = d;
      in_msb    = msb[ST-1:0];
      in_zero   = z;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("busy_ready", {63'd0, in_ready}, 64'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         junk_inputs();
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      check("latency", 64'(lat), 64'(ST));
      check("out_valid", {63'd0, out_valid}, 64'd1);
      check("out_data", {32'd0, out_data}, {32'd0, ed});
      check("out_err", {63'd0, out_err}, {63'd0, ee});
      for (int h = 0; h < hold; h++) begin
         junk_inputs();
         out_ready = 1'b0;
         @(negedge clk);
         check("hold_state", {29'd0, out_valid, in_ready, out_err, out_data},
               {29'd0, 1'b1, 1'b0, ee, ed});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release", {30'd0, out_valid, in_ready, out_data}, {30'd0, 1'b0, 1'b1, 32'd0});
   endtask

   task automatic reset_mid_spread();
      int seen;
      in_valid  = 1'b1;
      in_data   = 32'hFFFF_FA5C;
      in_msb    = 5'd11;
      in_zero   = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out", {30'd0, out_valid, out_err, out_data}, 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_beat_after_rst", 64'(seen), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] above;
      logic [63:0] low;
      logic [31:0] d;
      int          msb;
      int          cat;
      rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_msb = 5'd0; in_zero = 1'b0; out_ready = 1'b0;
      #12;
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_out", {30'd0, out_valid, out_err, out_data}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      send(32'hFFFF_FA5C, 11, 1'b0, 0);
      send(32'hFFFF_FFFF, 7,  1'b1, 1);
      send(32'hFFFF_FFFE, 0,  1'b1, 0);
      send(32'h7FFF_FA5C, 11, 1'b0, 0);
      send(32'hFFFF_F25C, 11, 1'b0, 2);
      send(32'h8000_0001, 31, 1'b0, 0);
      send(32'hFFFF_FFFF, 0,  1'b0, 0);
      send(32'hFFFF_FA5C, 11, 1'b0, 3);
      reset_mid_spread();
      send(32'hFFFF_FA5C, 11, 1'b0, 0);

      for (int t = 0; t < 150; t++) begin
         msb   = $urandom_range(0, 31);
         above = ~((64'd1 << (msb + 1)) - 64'd1);
         low   = (64'd1 << msb) - 64'd1;
         d     = above[31:0] | low[31:0] & $urandom;
         d[msb] = 1'b1;
         cat   = $urandom_range(0, 9);
         if (cat == 0) begin
            d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            send(d, msb, 1'b1, $urandom_range(0, 3));
         end else begin
            if (cat == 1) d[$urandom_range(0, 31)] ^= 1'b1;
            send(d, msb, 1'b0, $urandom_range(0, 3));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/restore_above_msb.md
RESTORE_ABOVE_MSB -- requirements
Module: restore_above_msb

Interface
REQ-001 SHALL have parameter N, default 32: word width; N >= 2.
REQ-002 SHALL have localparam STAGES, equal to ceil(log2(N)): the number of spread iterations and the width of the index port.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, width 1: the upstream word is valid.
REQ-006 SHALL have port in_ready, output, width 1: the block can accept a word.
REQ-007 SHALL have port in_data, input, width N: a word already transformed by invert-above-MSB (bits above the MSB forced to 1).
REQ-008 SHALL have port in_msb, input, width STAGES: the MSB index of the original word.
REQ-009 SHALL have port in_zero, input, width 1: the original word was 0, and in_msb is ignored.
REQ-010 SHALL have port out_valid, output, width 1: the restored word is valid.
REQ-011 SHALL have port out_ready, input, width 1: downstream accepts the restored word.
REQ-012 SHALL have port out_data, output, width N: the restored original word.
REQ-013 SHALL have port out_err, output, width 1: the input word was inconsistent with in_msb/in_zero.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SPREAD, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, so transfers never overlap.
REQ-016 SHALL, on an IDLE edge with in_valid=1, capture in_data, in_msb and in_zero.
- Mask is loaded as one-hot (1 << in_msb), or all-zero if in_zero=1.
- Stage counter cleared to 0; next state SPREAD.
REQ-017 SHALL, on each SPREAD edge, set mask = mask | (mask >> (1 << stage)) and increment stage.
- After the STAGES-th update, next state DONE.
- Result: mask = ones from bit in_msb down to bit 0.
REQ-018 SHALL assert out_valid exactly in DONE: first high in the cycle following edge k+STAGES, where edge k is acceptance.
- For N=32, out_valid rises 5 edges after acceptance.
REQ-019 SHALL drive out_data = captured word AND mask in DONE, and 0 otherwise.
REQ-020 SHALL drive out_err in DONE and 0 otherwise; out_err=1 iff any of:
- in_zero=0 and any captured bit above in_msb is 0;
- in_zero=0 and captured bit in_msb is 0;
- in_zero=0 and in_msb >= N;
- in_zero=1 and captured word is not all ones.
REQ-021 SHALL evaluate out_err from registered state only (captured word, index, zero flag), never from live inputs.
REQ-022 SHALL, if in_msb >= N with in_zero=0, load the mask as all-zero, so out_data=0 and out_err=1.
REQ-023 SHALL hold out_data and out_err stable in DONE while out_ready=0.
REQ-024 SHALL, on a DONE edge with out_ready=1, move to IDLE; in_ready rises the following cycle, so back-to-back throughput is one word per STAGES+2 cycles.
REQ-025 SHALL ignore in_valid, in_data, in_msb and in_zero outside IDLE, and ignore out_ready outside DONE.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force state IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, and clear mask, stage and captured registers.
REQ-027 SHALL, on reset asserted mid-SPREAD or in DONE, drop the in-flight word with no output beat; the first edge after rst falls may accept a new word.

Verification (N=32, STAGES=5)
REQ-028 SHALL cover: in_data=0xFFFFFA5C, in_msb=11, in_zero=0 -> out_valid 5 edges after acceptance, out_data=0x00000A5C, out_err=0.
REQ-029 SHALL cover: in_data=0xFFFFFFFF, in_zero=1, in_msb=7 -> out_data=0x00000000, out_err=0; and in_data=0xFFFFFFFE, in_zero=1 -> out_data=0, out_err=1.
REQ-030 SHALL cover:
- in_data=0x7FFFFA5C, in_msb=11 -> out_data=0x00000A5C, out_err=1;
- in_data=0xFFFFF25C, in_msb=11 (bit 11 clear) -> out_data=0x0000025C, out_err=1.
REQ-031 SHALL cover: in_data=0x80000001, in_msb=31 -> out_data=0x80000001, out_err=0; and in_data=0xFFFFFFFF, in_msb=0 -> out_data=0x00000001, out_err=0.
REQ-032 SHALL cover: out_ready held 0 for 3 cycles in DONE -> out_valid/out_data/out_err stable and in_ready=0 throughout; a one-cycle out_ready=1 pulse -> IDLE next cycle, exactly one transfer.
REQ-033 SHALL cover: rst pulsed at SPREAD stage 2 -> same-cycle in_ready=1, out_valid=0; a following word restores correctly with normal latency.
